data_memory_sized: RTL
======================

Name: data_memory_sized

Overview:
Parametrised successor data memory for the pipelined CPU's MEM stage.
- Byte-addressed, little-endian, with byte/half/word loads and stores plus sign/zero extension.
- Reads are registered (1-cycle latency); the read-during-write policy is selectable.
- On reset, an FSM clears the array before accepting accesses.
- Misaligned and out-of-range accesses are flagged and suppressed.

Parameters:
DEPTH, 64, number of 32-bit words (power of two, >=4).
ADDR_WIDTH, 32, byte-address width.
WRITE_FIRST, 1, 1 = same-cycle read of a written word returns new data; 0 = returns old data.

Ports:
clk  input  1  clock, all logic on posedge
resetN  input  1  asynchronous active-low reset
address  input  ADDR_WIDTH  byte address
writeData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
memWrite  input  1  store request
memRead  input  1  load request
accessSize  input  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
loadUnsigned  input  1  1 = zero-extend loads, 0 = sign-extend
readData  output  32  registered load result
readValid  output  1  one-cycle pulse, readData valid
misaligned  output  1  registered error flag for the accepted access
outOfRange  output  1  registered error flag for the accepted access
busy  output  1  high while clearing; requests ignored

Behaviour:
- Reset (resetN low, async): readData=0, readValid=0, misaligned=0, outOfRange=0, busy=1, state=CLEAR, clrCnt=0.
- FSM CLEAR: each cycle mem[clrCnt]<=0, clrCnt++. At clrCnt==DEPTH-1, go to READY next cycle; busy falls on the READY entry edge. CLEAR therefore lasts exactly DEPTH cycles after reset release.
- FSM READY: accept a request when memRead|memWrite. There is no back-pressure; one request per cycle.
- Requests during CLEAR are dropped with no flags and no readValid.
- Reset asserted mid-CLEAR or mid-access returns to CLEAR with clrCnt=0 and outputs at reset values. Contents are undefined until the clear completes.
- Word index = address[2+log2(DEPTH)-1:2]. outOfRange is set if any of address[ADDR_WIDTH-1:2+log2(DEPTH)] is nonzero.
- misaligned conditions:
  - half with address[0]=1;
  - word with address[1:0]!=0;
  - accessSize=11.
- Error precedence: misaligned then outOfRange; both flags may be 1.
- On error: no write, readData=0, readValid=memRead. Flags are registered 1 cycle after the request and held for one cycle.
- Store: lane k = bits [8k+7:8k], selected by address[1:0].
  - Byte writes lane address[1:0].
  - Half writes lanes address[1]*2 and address[1]*2+1.
  - Word writes all lanes.
  - Unwritten lanes are preserved; array update is on the posedge.
- Load: readData registered on the next posedge after the request; readValid pulses that same cycle.
  - Selected byte or half is extracted and extended per loadUnsigned.
- memRead and memWrite together: both perform at the same address.
  - WRITE_FIRST=1: returned data is the merged post-write word.
  - WRITE_FIRST=0: returned data is the pre-write word.
- readData holds its last value when no read is accepted. readValid is 0 otherwise.
- Back-to-back store then load of the same word in consecutive cycles returns the stored data (array written before the read).

Decomposition:
- Package data_mem_pkg:
  - accessSize encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - FSM state enum {CLEAR, READY};
  - function for lane-mask generation.
- Sub-module load_align_ext: combinational extraction and sign/zero extension from a 32-bit word, address[1:0], size and loadUnsigned. It is reused by the cache fill path later.

Test Plan:
1. Reset then DEPTH=64: busy=1 for exactly 64 cycles after resetN rises. A read at cycle 10 is dropped (readValid=0). After busy=0, a word read of any address returns 0.
2. Word store 0x8899AABB at 0x10; byte store 0x7F at 0x11; word load 0x10 -> 0x88997FBB. Byte load 0x13 signed -> 0xFFFFFF88; unsigned -> 0x00000088.
3. Half store 0xF00D at 0x22; half load 0x22 signed -> 0xFFFFF00D. Half load 0x21 -> misaligned=1, readData=0, word unchanged.
4. Word access at 0x100 (DEPTH=64) -> outOfRange=1, no write. A subsequent load of 0x00 returns the prior value.
5. Same-cycle read+write of 0x04 (old 0x11111111, new 0x22222222): WRITE_FIRST=1 -> 0x22222222; WRITE_FIRST=0 -> 0x11111111.
6. resetN pulsed low during a store at cycle 3 of READY: outputs reset immediately, busy=1, a full 64-cycle clear follows, and all words read 0 afterwards.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the sized data memory:
// access-size encodings, FSM states and the store lane mask.
package data_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SIZE_BYTE: m = 4'b0001 << off;
            SIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Extracts a byte/half/word from a 32-bit word and sign/zero-extends it.
// Purely combinational so the cache fill path can share it.
module load_align_ext
    import data_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:   o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory for the MEM stage with
// registered reads, post-reset clearing FSM and access error flags.
module data_memory_sized
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [1:0]            accessSize,
    input  logic                  loadUnsigned,
    output logic [31:0]           readData,
    output logic                  readValid,
    output logic                  misaligned,
    output logic                  outOfRange,
    output logic                  busy
);

    localparam int IW = $clog2(DEPTH);

    state_t          r_state;
    logic [IW-1:0]   r_clrCnt;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_readData;
    logic            r_readValid;
    logic            r_mis;
    logic            r_oor;

    logic [IW-1:0]   w_idx;
    logic            w_oor;
    logic            w_mis;
    logic            w_err;
    logic            w_ready;
    logic            w_acc;
    logic            w_we;
    logic [3:0]      w_mask;
    logic [31:0]     w_bits;
    logic [31:0]     w_wdata;
    logic [31:0]     w_old;
    logic [31:0]     w_new;
    logic [31:0]     w_src;
    logic [31:0]     w_ld;

    assign w_idx = address[IW+1:2];
    assign w_oor = |address[ADDR_WIDTH-1:IW+2];

    always_comb begin
        w_mis = 1'b1;
        case (accessSize)
            SIZE_BYTE: w_mis = 1'b0;
            SIZE_HALF: w_mis = address[0];
            SIZE_WORD: w_mis = |address[1:0];
            default:   w_mis = 1'b1;
        endcase
    end

    assign w_err   = w_mis | w_oor;
    assign w_ready = (r_state == READY);
    assign w_acc   = w_ready & (memRead | memWrite);
    assign w_we    = w_ready & memWrite & ~w_err;

    assign w_mask = lane_mask(accessSize, address[1:0]);
    assign w_bits = {{8{w_mask[3]}}, {8{w_mask[2]}},
                     {8{w_mask[1]}}, {8{w_mask[0]}}};

    always_comb begin
        w_wdata = writeData;
        case (accessSize)
            SIZE_BYTE: w_wdata = {4{writeData[7:0]}};
            SIZE_HALF: w_wdata = {2{writeData[15:0]}};
            default:   w_wdata = writeData;
        endcase
    end

    assign w_old = r_mem[w_idx];
    assign w_new = (w_old & ~w_bits) | (w_wdata & w_bits);
    // Write-first returns the merged word when this cycle also stores.
    assign w_src = (WRITE_FIRST && w_we) ? w_new : w_old;

    load_align_ext u_ext (
        .i_word     (w_src),
        .i_off      (address[1:0]),
        .i_size     (accessSize),
        .i_unsigned (loadUnsigned),
        .o_data     (w_ld)
    );

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clrCnt] <= '0;
        end else if (w_we) begin
            r_mem[w_idx] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= CLEAR;
            r_clrCnt    <= '0;
            r_readData  <= '0;
            r_readValid <= 1'b0;
            r_mis       <= 1'b0;
            r_oor       <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_readValid <= 1'b0;
                    r_mis       <= 1'b0;
                    r_oor       <= 1'b0;
                    r_clrCnt    <= r_clrCnt + 1'b1;
                    if (r_clrCnt == IW'(DEPTH - 1)) begin
                        r_state <= READY;
                    end
                end
                READY: begin
                    r_readValid <= memRead;
                    r_mis       <= w_acc & w_mis;
                    r_oor       <= w_acc & w_oor;
                    if (memRead) begin
                        r_readData <= w_err ? 32'd0 : w_ld;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign readData   = r_readData;
    assign readValid  = r_readValid;
    assign misaligned = r_mis;
    assign outOfRange = r_oor;
    assign busy       = (r_state == CLEAR);

endmodule
